// File: rtl/dance_pkg.sv
// Shared definitions for the dance-game lanes: judgement codes, point values
// and the key FSM encoding.
package dance_pkg;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_PERFECT = 2'b01,
        RES_GOOD    = 2'b10,
        RES_BAD     = 2'b11
    } result_t;

    typedef enum logic {
        KEY_UP   = 1'b0,
        KEY_HELD = 1'b1
    } key_state_t;

    localparam int PT_PERFECT = 2;
    localparam int PT_GOOD    = 1;
    localparam int PT_BAD     = -2;
    localparam int PT_MISS    = -1;

    function automatic logic is_hit(input result_t r);
        return (r == RES_PERFECT) || (r == RES_GOOD);
    endfunction

endpackage

// File: rtl/note_lane_if.sv
// Control inputs and scoring outputs of one arrow lane.
interface note_lane_if #(
    parameter int DEPTH = 8,
    parameter int PT_W  = 6,
    parameter int CMB_W = 7
);
    import dance_pkg::*;

    logic                    run;
    logic                    step;
    logic                    spawn;
    logic                    key;
    logic [DEPTH-1:0]        lights;
    logic signed [PT_W-1:0]  score;
    logic [CMB_W-1:0]        combo;
    result_t                 result;
    logic                    miss;

    modport master (
        output run, step, spawn, key,
        input  lights, score, combo, result, miss
    );

    modport slave (
        input  run, step, spawn, key,
        output lights, score, combo, result, miss
    );

endinterface

// File: rtl/note_lane_key_edge.sv
// Key press detector: a press is the UP->HELD transition while the lane runs.
module key_edge
    import dance_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic key,
    output logic press
);

    key_state_t state, state_n;
    logic       key_d;

    // key_d comes out of reset high so a key already down at release is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KEY_HELD;
            key_d <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= state_n;
            key_d <= key;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
        state_n = state;
        press   = 1'b0;
        case (state)
            KEY_UP: begin
                if (key) begin
                    state_n = KEY_HELD;
                    press   = run & ~key_d;
                end
            end
            KEY_HELD: begin
                if (!key) state_n = KEY_UP;
            end
        endcase
    end

endmodule

// File: rtl/note_lane.sv
// One arrow column: shifts notes upward on step, judges key presses against
// the top rows, and keeps a saturating signed score and a combo count.
module note_lane
    import dance_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int GOOD_WIN = 1,
    parameter int PT_W     = 6,
    parameter int CMB_W    = 7
) (
    input  logic      clk,
    input  logic      rst_n,
    note_lane_if.slave bus
);

    localparam int TOP = DEPTH - 1;
    localparam int LOW = DEPTH - 1 - GOOD_WIN;
    localparam int SW  = PT_W + 2;

    localparam logic signed [SW-1:0] SCORE_MAX = SW'((2 ** (PT_W - 1)) - 1);
    localparam logic signed [SW-1:0] SCORE_MIN = SW'(-(2 ** (PT_W - 1)));

    logic                   press;
    logic                   advance;
    logic [DEPTH-1:0]       clr;
    logic [DEPTH-1:0]       post;
    logic [DEPTH-1:0]       lights_n;
    result_t                res_n;
    logic                   miss_n;
    logic signed [SW-1:0]   delta;
    logic signed [SW-1:0]   sum;
    logic signed [PT_W-1:0] score_n;
    logic [CMB_W-1:0]       combo_n;

    key_edge u_key_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (bus.run),
        .key   (bus.key),
        .press (press)
    );

    // Judge against the pre-step lamps, then shift what the press left behind.
    always_comb begin
        clr   = '0;
        res_n = RES_NONE;
        delta = '0;
        if (press) begin
            if (bus.lights[TOP]) begin
                clr[TOP] = 1'b1;
                res_n    = RES_PERFECT;
                delta    = SW'(PT_PERFECT);
            end else begin
                res_n = RES_BAD;
                delta = SW'(PT_BAD);
                // Ascending scan: the highest lit row in the window wins.
                for (int r = LOW; r < TOP; r++) begin
                    if (bus.lights[r]) begin
                        clr    = '0;
                        clr[r] = 1'b1;
                        res_n  = RES_GOOD;
                        delta  = SW'(PT_GOOD);
                    end
                end
            end
        end

        post     = bus.lights & ~clr;
        advance  = bus.run & bus.step;
        miss_n   = advance & post[TOP];
        lights_n = advance ? {post[DEPTH-2:0], bus.spawn} : post;
        if (miss_n) delta = delta + SW'(PT_MISS);
    end

    // Wide enough that score + delta can never wrap before the clamp.
    always_comb begin
        sum = SW'(bus.score) + delta;
        if (sum > SCORE_MAX)      score_n = SCORE_MAX[PT_W-1:0];
        else if (sum < SCORE_MIN) score_n = SCORE_MIN[PT_W-1:0];
        else                      score_n = sum[PT_W-1:0];
    end

    // A miss or BAD in the same cycle as a hit still breaks the chain.
    always_comb begin
        combo_n = bus.combo;
        if (res_n == RES_BAD || miss_n)
            combo_n = '0;
        else if (is_hit(res_n) && bus.combo != '1)
            combo_n = bus.combo + CMB_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every output register is reset; none of this state may power up unknown.
        if (!rst_n) begin
            bus.lights <= '0;
            bus.score  <= '0;
            bus.combo  <= '0;
            bus.result <= RES_NONE;
            bus.miss   <= 1'b0;
        end else begin
            bus.lights <= lights_n;
            bus.score  <= score_n;
            bus.combo  <= combo_n;
            bus.result <= res_n;
            bus.miss   <= miss_n;
        end
    end

endmodule
